rgb_pwm_ctrl: RTL and testbench
===============================

Name: rgb_pwm_ctrl

Overview:
- Memory-mapped PWM controller that drives the three PWM inputs of the on-chip RGB LED driver.
- Replaces the raw GPIO-bit LED control on the iomem bus.
- Decodes its own iomem window, holds per-channel duty registers, and generates glitch-free PWM from a programmable prescaler.
- Duty updates are shadowed and take effect only at a PWM period boundary.

Parameters:
- PWM_BITS, 8, PWM counter/duty width; legal range 4..8.
- PRESC_W, 16, prescaler register/counter width.
- ADDR_HI, 8'h05, iomem_addr[31:24] value that selects this block.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- iomem_valid  input  1  bus request valid
- iomem_ready  output  1  one-cycle acknowledge
- iomem_wstrb  input  4  byte write strobes; 0 = read
- iomem_addr  input  32  byte address
- iomem_wdata  input  32  write data
- iomem_rdata  output  32  read data, valid while iomem_ready=1
- pwm_r  output  1  red PWM to LED driver RGB2PWM
- pwm_g  output  1  green PWM to LED driver RGB1PWM
- pwm_b  output  1  blue PWM to LED driver RGB0PWM

Behaviour:
- Reset (clk edge with reset=1):
  - All registers and counters are cleared.
  - iomem_ready=0, iomem_rdata=0, pwm_r/g/b=0.
  - Any in-flight access is dropped with no ready.
- Bus decode and handshake:
  - Hit = iomem_valid && !iomem_ready && iomem_addr[31:24]==ADDR_HI.
  - On a hit, iomem_ready=1 on the next cycle for exactly one cycle, with iomem_rdata registered in the same cycle.
  - Register select = iomem_addr[3:2]; addr[23:4] and addr[1:0] are ignored.
  - A write updates only the bytes whose wstrb bit is set.
  - On a non-hit, iomem_ready=0 and iomem_rdata holds its last value.
- Register map:
  - 0 CTRL: [0] EN, [1] BREATHE (see Optional Feature). Other bits read 0.
  - 1 DUTY:
    - Shadow duties: [7:0] blue, [15:8] green, [23:16] red; the low PWM_BITS of each byte are used.
    - Reads return the shadow values. Any write sets PEND.
  - 2 PRESC: [PRESC_W-1:0] prescale value P.
  - 3 STATUS (read-only, writes ignored):
    - [PWM_BITS-1:0] current PWM count.
    - [8] PEND.
    - [31:16] period counter, 16-bit, wraps from 0xFFFF to 0.
- Prescaler:
  - presc_cnt counts 0..P. A tick fires in the cycle presc_cnt==P, then presc_cnt resets to 0.
  - P=0 gives a tick every cycle.
  - If P is written below the current presc_cnt, the counter wraps through the maximum value; no special case.
- PWM counter:
  - Advances only on a tick, over 0..MAX-1 where MAX = 2^PWM_BITS - 1.
  - When it steps from MAX-1 to 0, that is a period boundary.
  - At a period boundary:
    - If PEND is set, active duties <= shadow duties and PEND clears.
    - The period counter increments.
- Outputs (registered, one cycle after count/duty change):
  - pwm_x = EN && (pwm_cnt < active_duty_x).
  - Duty 0 = constant low; duty MAX = constant high, with no one-tick glitch.
- EN=0:
  - Outputs are forced low in the next cycle.
  - Prescaler and PWM counter are held at 0.
  - Shadow duties are copied to active duties every cycle and PEND clears.
- Write to DUTY in the same cycle as a period boundary: the boundary loads the old shadow values, and the new write sets PEND for the next boundary.

Optional Feature:
- Macro: RGB_PWM_BREATHE_EN.
- Defined:
  - CTRL[1] is writable.
  - When BREATHE=1 and EN=1, an 8-bit envelope env runs as a triangle: it steps +1 each period boundary from 0 up to 255, then -1 down to 0, repeating.
  - Effective duty = (active_duty_x * env) >> 8, computed as a 16-bit product and registered.
  - env resets to 0 when BREATHE=0 or EN=0.
  - STATUS[15:9] = env[7:1].
- Undefined:
  - CTRL[1] reads 0 and writes to it are ignored.
  - Effective duty = active duty.
  - STATUS[15:9] = 0.
  - No multiplier is inferred.

Test Plan:
1. Reset mid-access: assert valid to addr 0x05000004 and pulse reset in that cycle -> no iomem_ready; all outputs 0; DUTY reads back 0x00000000.
2. Byte strobes: write 0x00FF8040 to 0x05000004 with wstrb=4'b0110 -> readback 0x00FF8000; ready is high for exactly one cycle after valid; a non-matching addr 0x03000000 gets no ready from this block.
3. Basic PWM: P=0, EN=1, DUTY=0x00C0FF40 -> after the first boundary, pwm_b is high 64 of every 255 cycles, pwm_g is always high, pwm_r is high 192/255; STATUS[8] reads 1 before the boundary and 0 after.
4. Shadowing: mid-period, change blue duty 64→10 -> pwm_b keeps the 64-cycle width until the period boundary, then switches to 10; no runt pulse.
5. Prescale and EN: P=3 -> PWM period is 1020 cycles and the period counter advances once per 1020 cycles; clear EN mid-period -> all outputs low within 1 cycle and STATUS count reads 0.
6. Breathe (macro on): DUTY blue=255, BREATHE=1, P=0 -> high time per period follows env (0, 1, ... 254 cycles, then back down); with the macro off, the same writes give a constant 255/255 output and CTRL reads 0x1.

Source files
------------

// File: rtl/rgb_pwm_ctrl.sv
// iomem-mapped three-channel PWM controller for the RGB LED driver, with shadowed duty updates.
// Define RGB_PWM_BREATHE_EN to add the triangle "breathing" envelope on CTRL[1].

module rgb_pwm_ctrl #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PRESC_W  = 16,
    parameter logic [7:0]  ADDR_HI  = 8'h05
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b
);

    localparam int unsigned         PwmMax  = (1 << PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] CntLast = PWM_BITS'(PwmMax - 1);

    typedef enum logic [1:0] {
        RegCtrl   = 2'd0,
        RegDuty   = 2'd1,
        RegPresc  = 2'd2,
        RegStatus = 2'd3
    } reg_sel_e;

    logic                en_q;
    logic [23:0]         shadow_q;
    logic [PRESC_W-1:0]  presc_q;
    logic [PRESC_W-1:0]  presc_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pend_q;
    logic [15:0]         period_q;
    logic [PWM_BITS-1:0] act_r_q, act_g_q, act_b_q;
    logic [PWM_BITS-1:0] eff_r, eff_g, eff_b;

    logic                hit, wr, wr_ctrl, wr_duty, wr_presc;
    reg_sel_e            sel;
    logic                en_d;
    logic [23:0]         shadow_d;
    logic [PRESC_W-1:0]  presc_d;
    logic [31:0]         rd_word;
    logic                tick, boundary;
    logic                unused_bits;

    assign hit      = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
    assign wr       = hit && (iomem_wstrb != 4'b0000);
    assign sel      = reg_sel_e'(iomem_addr[3:2]);
    assign wr_ctrl  = wr && (sel == RegCtrl);
    assign wr_duty  = wr && (sel == RegDuty);
    assign wr_presc = wr && (sel == RegPresc);

    assign tick     = en_q && (presc_cnt_q == presc_q);
    assign boundary = tick && (pwm_cnt_q == CntLast);

    assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:24]};

    // Byte-strobe merge of the write data into each register's next value.
    always_comb begin
        en_d     = iomem_wstrb[0] ? iomem_wdata[0] : en_q;
        shadow_d = shadow_q;
        presc_d  = presc_q;
        for (int i = 0; i < 24; i++) begin
            if (iomem_wstrb[i/8]) shadow_d[i] = iomem_wdata[i];
        end
        for (int i = 0; i < int'(PRESC_W); i++) begin
            if (iomem_wstrb[i/8]) presc_d[i] = iomem_wdata[i];
        end
    end

`ifdef RGB_PWM_BREATHE_EN
    logic                breathe_q;
    logic [7:0]          env_q;
    logic                env_down_q;
    logic [PWM_BITS-1:0] eff_r_q, eff_g_q, eff_b_q;
    logic [15:0]         prod_r, prod_g, prod_b;
    logic                unused_prod;

    assign prod_r      = 16'(act_r_q) * 16'(env_q);
    assign prod_g      = 16'(act_g_q) * 16'(env_q);
    assign prod_b      = 16'(act_b_q) * 16'(env_q);
    assign unused_prod = ^{prod_r, prod_g, prod_b};

    always_ff @(posedge clk) begin
        if (reset) begin
            breathe_q  <= 1'b0;
            env_q      <= 8'd0;
            env_down_q <= 1'b0;
            eff_r_q    <= '0;
            eff_g_q    <= '0;
            eff_b_q    <= '0;
        end else begin
            if (wr_ctrl && iomem_wstrb[0]) breathe_q <= iomem_wdata[1];
            if (!en_q || !breathe_q) begin
                env_q      <= 8'd0;
                env_down_q <= 1'b0;
            end else if (boundary) begin
                // Triangle: turn around at both ends rather than wrapping.
                if (env_down_q) begin
                    if (env_q == 8'd0) begin
                        env_down_q <= 1'b0;
                        env_q      <= 8'd1;
                    end else begin
                        env_q <= env_q - 8'd1;
                    end
                end else if (env_q == 8'hFF) begin
                    env_down_q <= 1'b1;
                    env_q      <= 8'hFE;
                end else begin
                    env_q <= env_q + 8'd1;
                end
            end
            eff_r_q <= breathe_q ? prod_r[PWM_BITS+7:8] : act_r_q;
            eff_g_q <= breathe_q ? prod_g[PWM_BITS+7:8] : act_g_q;
            eff_b_q <= breathe_q ? prod_b[PWM_BITS+7:8] : act_b_q;
        end
    end

    assign eff_r = eff_r_q;
    assign eff_g = eff_g_q;
    assign eff_b = eff_b_q;
`else
    assign eff_r = act_r_q;
    assign eff_g = act_g_q;
    assign eff_b = act_b_q;
`endif

    always_comb begin
        rd_word = '0;
        unique case (sel)
            RegCtrl: begin
                rd_word[0] = en_q;
`ifdef RGB_PWM_BREATHE_EN
                rd_word[1] = breathe_q;
`endif
            end
            RegDuty:  rd_word[23:0] = shadow_q;
            RegPresc: rd_word[PRESC_W-1:0] = presc_q;
            RegStatus: begin
                rd_word[PWM_BITS-1:0] = pwm_cnt_q;
                rd_word[8]            = pend_q;
`ifdef RGB_PWM_BREATHE_EN
                rd_word[15:9]         = env_q[7:1];
`endif
                rd_word[31:16]        = period_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            en_q        <= 1'b0;
            shadow_q    <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            pend_q      <= 1'b0;
            period_q    <= '0;
            act_r_q     <= '0;
            act_g_q     <= '0;
            act_b_q     <= '0;
            pwm_r       <= 1'b0;
            pwm_g       <= 1'b0;
            pwm_b       <= 1'b0;
        end else begin
            iomem_ready <= hit;
            if (hit)      iomem_rdata <= rd_word;
            if (wr_ctrl)  en_q        <= en_d;
            if (wr_duty)  shadow_q    <= shadow_d;
            if (wr_presc) presc_q     <= presc_d;

            if (!en_q) begin
                presc_cnt_q <= '0;
                pwm_cnt_q   <= '0;
            end else if (tick) begin
                presc_cnt_q <= '0;
                pwm_cnt_q   <= boundary ? '0 : pwm_cnt_q + PWM_BITS'(1);
            end else begin
                presc_cnt_q <= presc_cnt_q + PRESC_W'(1);
            end

            if (boundary) period_q <= period_q + 16'd1;

            // A boundary coincident with a DUTY write loads the pre-write shadow.
            if (!en_q || (boundary && pend_q)) begin
                act_b_q <= shadow_q[PWM_BITS-1:0];
                act_g_q <= shadow_q[8 +: PWM_BITS];
                act_r_q <= shadow_q[16 +: PWM_BITS];
            end

            if (wr_duty)                 pend_q <= 1'b1;
            else if (!en_q || boundary)  pend_q <= 1'b0;

            pwm_r <= en_q && (pwm_cnt_q < eff_r);
            pwm_g <= en_q && (pwm_cnt_q < eff_g);
            pwm_b <= en_q && (pwm_cnt_q < eff_b);
        end
    end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Self-checking bench for rgb_pwm_ctrl: register vectors, PWM duty measurement, shadowing,
// prescaler timing and randomized duty/prescale checks against arithmetic expectations.

module tb_rgb_pwm_ctrl;

    localparam logic [31:0] ACtrl  = 32'h0500_0000;
    localparam logic [31:0] ADuty  = 32'h0500_0004;
    localparam logic [31:0] APresc = 32'h0500_0008;
    localparam logic [31:0] AStat  = 32'h0500_000C;
`ifdef RGB_PWM_BREATHE_EN
    localparam logic [31:0] CtrlAll = 32'h3;
`else
    localparam logic [31:0] CtrlAll = 32'h1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        pwm_r, pwm_g, pwm_b;

    int checks = 0;
    int errors = 0;

    rgb_pwm_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .pwm_r       (pwm_r),
        .pwm_g       (pwm_g),
        .pwm_b       (pwm_b)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Blue high-run length monitor, sampled 1 time unit after each rising edge.
    logic log_clear = 1'b0;
    int   cur_run = 0;
    int   runs[$];
    always @(posedge clk) begin
        #1;
        if (log_clear) begin
            runs.delete();
            cur_run = 0;
        end else if (pwm_b) begin
            cur_run++;
        end else if (cur_run > 0) begin
            runs.push_back(cur_run);
            cur_run = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                       output logic [31:0] rd);
        int lat;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = data;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!iomem_ready && lat < 8);
        rd = iomem_rdata;
        check("bus_latency", 32'(lat), 32'd1);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
        logic [31:0] dummy;
        bus(addr, strb, data, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] d);
        bus(addr, 4'h0, 32'h0, d);
    endtask

    task automatic count_highs(input int n, output int cr, output int cg, output int cb);
        cr = 0; cg = 0; cb = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cr += int'(pwm_r);
            cg += int'(pwm_g);
            cb += int'(pwm_b);
        end
    endtask

    task automatic wait_b(input logic lvl, input string nm);
        int n = 0;
        while (pwm_b !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(pwm_b), 32'(lvl));
    endtask

    // Reference: high cycles per PWM period = duty ticks, each tick lasting P+1 cycles.
    function automatic int exp_high(input int duty, input int p);
        return duty * (p + 1);
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] d, d2;
        int cr, cg, cb, bad;
        logic [7:0] rb, rg, rr;
        int p;

        vecs[0]  = '{ACtrl,         4'hF, 32'hFFFF_FFFF, CtrlAll};
        vecs[1]  = '{ACtrl,         4'hF, 32'h0000_0000, 32'h0};
        vecs[2]  = '{APresc,        4'h1, 32'h00AA_AA55, 32'h0000_0055};
        vecs[3]  = '{APresc,        4'h2, 32'h1234_5678, 32'h0000_5655};
        vecs[4]  = '{32'h0500_000B, 4'hC, 32'hFFFF_FFFF, 32'h0000_5655};
        vecs[5]  = '{APresc,        4'hF, 32'h0000_0000, 32'h0};
        vecs[6]  = '{ADuty,         4'hF, 32'hDEAD_BEEF, 32'h00AD_BEEF};
        vecs[7]  = '{32'h05FF_FFF4, 4'h8, 32'h1100_0000, 32'h00AD_BEEF};
        vecs[8]  = '{ADuty,         4'h4, 32'h0022_0000, 32'h0022_BEEF};
        vecs[9]  = '{ADuty,         4'h1, 32'h0000_0003, 32'h0022_BE03};
        vecs[10] = '{AStat,         4'hF, 32'hFFFF_FFFF, 32'h0};

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset arriving with an access in flight drops it.
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = ADuty;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h00AB_CDEF;
        reset       = 1'b1;
        @(negedge clk);
        check("rst_no_ready", 32'(iomem_ready), 32'd0);
        reset       = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge clk);
        check("rst_no_late_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'h0);
        check("rst_pwm", 32'({pwm_r, pwm_g, pwm_b}), 32'd0);
        rd(ADuty, d);
        check("rst_duty", d, 32'h0);

        // Byte strobes and single-cycle ready.
        wr(ADuty, 4'b0110, 32'h00FF_8040);
        @(negedge clk);
        check("ready_one_cycle", 32'(iomem_ready), 32'd0);
        rd(ADuty, d);
        check("strobe_readback", d, 32'h00FF_8000);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        cr = 0;
        repeat (6) begin
            @(negedge clk);
            cr += int'(iomem_ready);
        end
        iomem_valid = 1'b0;
        check("foreign_addr_no_ready", 32'(cr), 32'd0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wstrb != 4'h0) wr(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata);
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        // Basic PWM with P=0.
        wr(APresc, 4'hF, 32'h0);
        wr(ACtrl, 4'hF, 32'h1);
        wr(ADuty, 4'hF, 32'h00C0_FF40);
        rd(AStat, d);
        check("pend_before_boundary", 32'(d[8]), 32'd1);
        repeat (300) @(negedge clk);
        count_highs(255, cr, cg, cb);
        check("basic_b", 32'(cb), 32'd64);
        check("basic_g", 32'(cg), 32'd255);
        check("basic_r", 32'(cr), 32'd192);
        rd(AStat, d);
        check("pend_after_boundary", 32'(d[8]), 32'd0);
        rd(AStat, d);
        repeat (255 * 4 - 2) @(negedge clk);
        rd(AStat, d2);
        check("period_cnt_p0", 32'(d2[31:16] - d[31:16]), 32'd4);

        // Shadowing: blue 64 -> 10 written mid-pulse.
        wait_b(1'b1, "sync_rise");
        wait_b(1'b0, "sync_fall");
        log_clear = 1'b1;
        @(negedge clk);
        log_clear = 1'b0;
        wait_b(1'b1, "shadow_rise");
        repeat (5) @(negedge clk);
        wr(ADuty, 4'hF, 32'h00C0_FF0A);
        repeat (800) @(negedge clk);
        check("shadow_runs_seen", 32'(runs.size() >= 3), 32'd1);
        if (runs.size() > 0) check("shadow_first_run", 32'(runs[0]), 32'd64);
        bad = 0;
        for (int i = 1; i < runs.size(); i++) if (runs[i] != 10) bad++;
        check("shadow_later_runs", 32'(bad), 32'd0);

        // Prescale P=3 and EN clear.
        wr(APresc, 4'h3, 32'h0000_0003);
        repeat (1100) @(negedge clk);
        count_highs(1020, cr, cg, cb);
        check("presc_r", 32'(cr), 32'd768);
        check("presc_g", 32'(cg), 32'd1020);
        check("presc_b", 32'(cb), 32'd40);
        rd(AStat, d);
        repeat (1020 * 3 - 2) @(negedge clk);
        rd(AStat, d2);
        check("period_cnt_p3", 32'(d2[31:16] - d[31:16]), 32'd3);
        wr(ACtrl, 4'h1, 32'h0);
        @(negedge clk);
        check("en_off_pwm", 32'({pwm_r, pwm_g, pwm_b}), 32'd0);
        rd(AStat, d);
        check("en_off_count", 32'(d[7:0]), 32'd0);

        // Randomized duties and prescale against the per-period arithmetic model.
        for (int it = 0; it < 8; it++) begin
            rb = 8'($urandom_range(0, 255));
            rg = 8'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, 255));
            p  = int'($urandom_range(0, 2));
            if (it == 0) begin rb = 8'd0;   rg = 8'd255; rr = 8'd1;   end
            if (it == 1) begin rb = 8'd254; rg = 8'd128; rr = 8'd255; end
            wr(ACtrl, 4'hF, 32'h0);
            wr(APresc, 4'hF, 32'(p));
            wr(ADuty, 4'hF, {8'h00, rr, rg, rb});
            wr(ACtrl, 4'hF, 32'h1);
            repeat (3) @(negedge clk);
            count_highs(255 * (p + 1), cr, cg, cb);
            check($sformatf("rand%0d_r", it), 32'(cr), 32'(exp_high(int'(rr), p)));
            check($sformatf("rand%0d_g", it), 32'(cg), 32'(exp_high(int'(rg), p)));
            check($sformatf("rand%0d_b", it), 32'(cb), 32'(exp_high(int'(rb), p)));
        end

        // BREATHE bit.
        wr(ACtrl, 4'hF, 32'h0);
`ifdef RGB_PWM_BREATHE_EN
        wr(APresc, 4'hF, 32'h0);
        wr(ADuty, 4'hF, 32'h0000_00FF);
        wr(ACtrl, 4'hF, 32'h3);
        rd(ACtrl, d);
        check("breathe_ctrl", d, 32'h3);
        repeat (2647) @(negedge clk);
        rd(AStat, d);
        check("breathe_env", 32'(d[15:9]), 32'd5);
`else
        wr(APresc, 4'hF, 32'h3);
        wr(ADuty, 4'hF, 32'h0000_00FF);
        wr(ACtrl, 4'hF, 32'h3);
        rd(ACtrl, d);
        check("breathe_ctrl", d, 32'h1);
        repeat (10) @(negedge clk);
        count_highs(1020, cr, cg, cb);
        check("breathe_off_b", 32'(cb), 32'd1020);
        rd(AStat, d);
        check("breathe_off_env", 32'(d[15:9]), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
